tank_square_object: RTL and testbench



---
 rtl/battle_city_pkg.sv | 20 ++
 rtl/square_object_window.sv | 30 +++
 rtl/tank_square_object.sv | 155 +++++++++++++++
 tb/tb_tank_square_object.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/battle_city_pkg.sv
// Shared types and screen geometry for the tank playfield objects.
package battle_city_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    MOVING  = 2'd1,
    BLOCKED = 2'd2
  } tank_state_t;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

endpackage

// File: rtl/square_object_window.sv
// Combinational box test of the scan pixel against the object rectangle,
// with pixel offsets relative to the top-left corner while inside.
module square_object_window #(
  parameter int OBJECT_WIDTH_X  = 25,
  parameter int OBJECT_HEIGHT_Y = 25
) (
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY
);

  localparam logic [11:0] W = 12'(OBJECT_WIDTH_X);
  localparam logic [11:0] H = 12'(OBJECT_HEIGHT_Y);

  logic in_x;
  logic in_y;

  // right/bottom edges computed in 12 bits so a box near 2047 cannot wrap
  assign in_x = (pixelX >= topLeftX) && ({1'b0, pixelX} < ({1'b0, topLeftX} + W));
  assign in_y = (pixelY >= topLeftY) && ({1'b0, pixelY} < ({1'b0, topLeftY} + H));

  assign InsideRectangle = in_x && in_y;
  assign offsetX = InsideRectangle ? (pixelX - topLeftX) : 11'd0;
  assign offsetY = InsideRectangle ? (pixelY - topLeftY) : 11'd0;

endmodule

// File: rtl/tank_square_object.sv
// Keyboard-driven tank: frame-synchronous STOPPED/MOVING/BLOCKED FSM with
// collision revert. Define TANK_WRAP_EN to wrap at screen edges instead of clamping.
//
// state   | meaning
// STOPPED | no key held, position frozen
// MOVING  | steps SPEED pixels per frame along the winning key
// BLOCKED | hit an obstacle, waits for a different key or release
module tank_square_object
  import battle_city_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 25,
  parameter int OBJECT_HEIGHT_Y = 25,
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int SPEED           = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        keyUp,
  input  logic        keyDown,
  input  logic        keyLeft,
  input  logic        keyRight,
  input  logic        collision,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output dir_t        direction
);

  localparam logic [10:0]        INIT_X = 11'(INITIAL_X);
  localparam logic [10:0]        INIT_Y = 11'(INITIAL_Y);
  localparam logic [10:0]        MAX_X  = 11'(SCREEN_WIDTH - OBJECT_WIDTH_X);
  localparam logic [10:0]        MAX_Y  = 11'(SCREEN_HEIGHT - OBJECT_HEIGHT_Y);
  localparam logic signed [11:0] STEP   = 12'(SPEED);

  tank_state_t       state_q;
  logic [10:0]       prev_x;
  logic [10:0]       prev_y;
  logic              col_latch;
  logic              any_key;
  dir_t              win_dir;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic [10:0]       step_x;
  logic [10:0]       step_y;

  function automatic logic [10:0] limit_axis(input logic signed [11:0] v,
                                              input logic [10:0] lim);
    logic [10:0] r;
`ifdef TANK_WRAP_EN
    if (v < 12'sd0)                    r = lim;
    else if (v > $signed({1'b0, lim})) r = 11'd0;
    else                               r = v[10:0];
`else
    if (v < 12'sd0)                    r = 11'd0;
    else if (v > $signed({1'b0, lim})) r = lim;
    else                               r = v[10:0];
`endif
    return r;
  endfunction

  always_comb begin
    any_key = keyUp | keyDown | keyLeft | keyRight;
    if (keyUp)        win_dir = UP;
    else if (keyDown) win_dir = DOWN;
    else if (keyLeft) win_dir = LEFT;
    else              win_dir = RIGHT;
    dx = 12'sd0;
    dy = 12'sd0;
    case (win_dir)
      UP:      dy = -STEP;
      DOWN:    dy = STEP;
      LEFT:    dx = -STEP;
      default: dx = STEP;
    endcase
    step_x = limit_axis($signed({1'b0, topLeftX}) + dx, MAX_X);
    step_y = limit_axis($signed({1'b0, topLeftY}) + dy, MAX_Y);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= STOPPED;
      direction <= UP;
      topLeftX  <= INIT_X;
      topLeftY  <= INIT_Y;
      prev_x    <= INIT_X;
      prev_y    <= INIT_Y;
      col_latch <= 1'b0;
    end else if (startOfFrame) begin
      // a collision landing on the frame boundary belongs to the new frame
      col_latch <= collision;
      case (state_q)
        STOPPED: begin
          if (any_key) begin
            state_q   <= MOVING;
            direction <= win_dir;
            prev_x    <= topLeftX;
            prev_y    <= topLeftY;
            topLeftX  <= step_x;
            topLeftY  <= step_y;
          end
        end
        MOVING: begin
          if (col_latch) begin
            state_q  <= BLOCKED;
            topLeftX <= prev_x;
            topLeftY <= prev_y;
          end else if (!any_key) begin
            state_q <= STOPPED;
          end else begin
            direction <= win_dir;
            prev_x    <= topLeftX;
            prev_y    <= topLeftY;
            topLeftX  <= step_x;
            topLeftY  <= step_y;
          end
        end
        BLOCKED: begin
          if (!any_key) begin
            state_q <= STOPPED;
          end else if (win_dir != direction) begin
            state_q   <= MOVING;
            direction <= win_dir;
            prev_x    <= topLeftX;
            prev_y    <= topLeftY;
            topLeftX  <= step_x;
            topLeftY  <= step_y;
          end
        end
        default: state_q <= STOPPED;
      endcase
    end else if (collision) begin
      col_latch <= 1'b1;
    end
  end

  square_object_window #(
    .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
    .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y)
  ) u_window (
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .InsideRectangle(InsideRectangle),
    .offsetX        (offsetX),
    .offsetY        (offsetY)
  );

endmodule

// File: tb/tb_tank_square_object.sv
// Directed bench for tank_square_object: movement FSM, collision revert,
// edge handling and the pixel window.
module tb_tank_square_object;
  import battle_city_pkg::*;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, keyUp, keyDown, keyLeft, keyRight, collision;
  logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
  logic        InsideRectangle;
  dir_t        direction;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int px;
    int py;
    int ins;
    int ox;
    int oy;
  } win_vec_t;

  win_vec_t vecs[8];

  always #5 clk = ~clk;

  tank_square_object dut (
    .clk            (clk),
    .resetN         (resetN),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .startOfFrame   (startOfFrame),
    .keyUp          (keyUp),
    .keyDown        (keyDown),
    .keyLeft        (keyLeft),
    .keyRight       (keyRight),
    .collision      (collision),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .InsideRectangle(InsideRectangle),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .direction      (direction)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tank(input string name, input int x, input int y,
                            input dir_t d, input tank_state_t s);
    check({name, " x"}, int'(topLeftX), x);
    check({name, " y"}, int'(topLeftY), y);
    check({name, " dir"}, int'(direction), int'(d));
    check({name, " state"}, int'(dut.state_q), int'(s));
  endtask

  task automatic set_keys(input logic u, input logic d, input logic l, input logic r);
    keyUp = u; keyDown = d; keyLeft = l; keyRight = r;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 startOfFrame = 1'b1;
      @(posedge clk); #1 startOfFrame = 1'b0;
    end
  endtask

  task automatic frame_with_collision();
    @(posedge clk); #1 startOfFrame = 1'b1; collision = 1'b1;
    @(posedge clk); #1 startOfFrame = 1'b0; collision = 1'b0;
  endtask

  task automatic pulse_collision();
    @(posedge clk); #1 collision = 1'b1;
    @(posedge clk); #1 collision = 1'b0;
  endtask

  initial begin
    vecs[0] = '{124, 74, 1, 24, 24};
    vecs[1] = '{125, 74, 0, 0, 0};
    vecs[2] = '{100, 50, 1, 0, 0};
    vecs[3] = '{99, 50, 0, 0, 0};
    vecs[4] = '{100, 49, 0, 0, 0};
    vecs[5] = '{124, 75, 0, 0, 0};
    vecs[6] = '{110, 60, 1, 10, 10};
    vecs[7] = '{0, 0, 0, 0, 0};

    resetN = 1'b0; pixelX = '0; pixelY = '0; startOfFrame = 1'b0;
    collision = 1'b0; set_keys(0, 0, 0, 0);
    #22 resetN = 1'b1;
    check_tank("reset", 280, 185, UP, STOPPED);

    frames(3);
    check_tank("idle 3 frames", 280, 185, UP, STOPPED);

    set_keys(0, 0, 0, 1);
    frames(5);
    check_tank("right 5 frames", 285, 185, RIGHT, MOVING);

    frames(15);
    check_tank("right to 300", 300, 185, RIGHT, MOVING);
    pulse_collision();
    check_tank("no change mid-frame", 300, 185, RIGHT, MOVING);
    frames(1);
    check_tank("collision revert", 299, 185, RIGHT, BLOCKED);
    frames(1);
    check_tank("same key stays blocked", 299, 185, RIGHT, BLOCKED);
    set_keys(1, 0, 0, 0);
    frames(1);
    check_tank("new key unblocks", 299, 184, UP, MOVING);

    set_keys(1, 0, 0, 1);
    frames(1);
    check_tank("up beats right", 299, 183, UP, MOVING);
    frame_with_collision();
    check_tank("boundary collision deferred", 299, 182, UP, MOVING);
    frames(1);
    check_tank("deferred collision applied", 299, 183, UP, BLOCKED);

    set_keys(0, 0, 0, 0);
    frames(1);
    check_tank("release from blocked", 299, 183, UP, STOPPED);

    set_keys(0, 0, 1, 0);
    frames(199);
    set_keys(1, 0, 0, 0);
    frames(133);
    set_keys(0, 0, 0, 0);
    frames(1);
    check_tank("reach 100,50", 100, 50, UP, STOPPED);

    for (int i = 0; i < 8; i++) begin
      pixelX = 11'(vecs[i].px);
      pixelY = 11'(vecs[i].py);
      #1;
      check($sformatf("win%0d inside", i), int'(InsideRectangle), vecs[i].ins);
      check($sformatf("win%0d offX", i), int'(offsetX), vecs[i].ox);
      check($sformatf("win%0d offY", i), int'(offsetY), vecs[i].oy);
    end
    pixelX = '0; pixelY = '0;

    set_keys(0, 1, 0, 0);
    frames(50);
    set_keys(0, 0, 1, 0);
    frames(100);
    check_tank("reach 0,100", 0, 100, LEFT, MOVING);
    frames(1);
`ifdef TANK_WRAP_EN
    check("left edge frame1", int'(topLeftX), 615);
`else
    check("left edge frame1", int'(topLeftX), 0);
`endif
    frames(1);
`ifdef TANK_WRAP_EN
    check("left edge frame2", int'(topLeftX), 614);
`else
    check("left edge frame2", int'(topLeftX), 0);
`endif
    check("left edge y", int'(topLeftY), 100);

    set_keys(0, 0, 0, 1);
    pulse_collision();
    @(posedge clk); #3 resetN = 1'b0;
    pixelX = 11'd304; pixelY = 11'd209;
    #1;
    check_tank("async reset", 280, 185, UP, STOPPED);
    check("reset window inside", int'(InsideRectangle), 1);
    check("reset window offX", int'(offsetX), 24);
    check("reset window offY", int'(offsetY), 24);
    @(negedge clk); resetN = 1'b1;
    pixelX = '0; pixelY = '0;
    frames(1);
    check_tank("post-reset step", 281, 185, RIGHT, MOVING);
    frames(1);
    check_tank("collision discarded", 282, 185, RIGHT, MOVING);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
